keypad_kbd_bridge: RTL and testbench
====================================

Name: keypad_kbd_bridge

Overview:
Consumer end of the keypad scanner's key event interface (key_index, key_valid 1-cycle pulse). It buffers key events in a small FIFO and maps each 4x4 index to ASCII. It presents each key in the Hack memory-mapped keyboard register format: 16-bit value, 0 = no key. Each key is held for a fixed time and then released to 0, so polling software sees a distinct press/release per event.

Parameters:
FIFO_DEPTH, 4, event buffer entries; power of 2, >= 2
HOLD_CYCLES, 1000000, cycles kbd_out holds a key code; >= 1
GAP_CYCLES, 1000, cycles kbd_out forced to 0 between consecutive keys; >= 1

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
key_index  input  4  key number 0-15 from scanner, index = row*4 + col
key_valid  input  1  1-cycle strobe, key_index valid
kbd_clear  input  1  CPU write to KBD: end current hold early
kbd_out  output  16  Hack KBD register value, 0 = no key
fifo_count  output  clog2(FIFO_DEPTH)+1  events buffered, not yet displayed
overflow  output  1  sticky: at least one event dropped
busy  output  1  high in HOLD or GAP

Behaviour:
- Only clock is clk. rst is synchronous and active-high; it is sampled on the clk rising edge.
- Reset values: kbd_out=0, fifo_count=0, overflow=0, busy=0, FSM=IDLE, all counters 0, FIFO pointers 0. Reset overrides every other input in the same cycle. A rst during HOLD drops the displayed key and all buffered events.
- ASCII map (index -> code, upper 8 bits 0):
  - 0-3: 0x31 0x32 0x33 0x41
  - 4-7: 0x34 0x35 0x36 0x42
  - 8-11: 0x37 0x38 0x39 0x43
  - 12-15: 0x2A 0x30 0x23 0x44
- FIFO stores the raw 4-bit index. The map is applied when an entry is loaded into kbd_out.
- Push: on the edge where key_valid=1.
  - Accepted if fifo_count < FIFO_DEPTH, or if a pop occurs on the same edge.
  - Otherwise the event is dropped and overflow is set. overflow is cleared only by rst.
- Pointers wrap modulo FIFO_DEPTH. fifo_count changes by +1, -1, or 0 (push and pop on the same edge).
- FSM states and transitions:
  - IDLE: kbd_out=0, busy=0. If fifo_count>0 (registered value): pop, set kbd_out=map(head), timer=0, go to HOLD.
  - HOLD: busy=1. timer increments each cycle.
    - On timer==HOLD_CYCLES-1, or kbd_clear=1: kbd_out<=0, timer=0, go to GAP.
    - kbd_clear is ignored in IDLE and GAP.
  - GAP: busy=1, kbd_out=0. On timer==GAP_CYCLES-1: go to IDLE.
- The FIFO is not bypassed. An event pushed while fifo_count==0 is popped on the next edge.
- Latency: key_valid high in the cycle before edge E0 -> FIFO written at E0 -> pop at E1 -> kbd_out valid after E1 (2 cycles).
- Hold length: kbd_out nonzero for exactly HOLD_CYCLES cycles, then 0 for exactly GAP_CYCLES cycles. The next key can appear 1 cycle later (IDLE pop cycle).
- Timer width: clog2(max(HOLD_CYCLES,GAP_CYCLES)). The timer never wraps.
- key_valid arriving during HOLD or GAP is buffered normally and does not disturb the current display.

Test Plan:
- Reset: assert rst 3 cycles with key_valid=1 -> kbd_out=0, fifo_count=0, overflow=0, busy=0 throughout and 1 cycle after release.
- Single key: HOLD=8, GAP=4, pulse key_index=5 -> kbd_out=0x0035 two cycles later for exactly 8 cycles, then 0 for 4 cycles, busy high for all 12.
- Full map: pulse indices 0..15 spaced >13 cycles apart -> kbd_out sequence 0x31,0x32,0x33,0x41,...,0x2A,0x30,0x23,0x44.
- Overflow: DEPTH=4, 6 back-to-back pulses (idx 0..5) -> idx0 popped at the edge after its push, so idx1-4 fit in the FIFO and idx5 is dropped. Displayed codes: 0x31,0x32,0x33,0x41,0x34. overflow=1 stays set.
- Full with same-edge pop: fill FIFO to 4 during GAP, push on the exact IDLE pop edge -> accepted, fifo_count stays 4, overflow=0.
- Early clear and mid-reset: kbd_clear in the 3rd HOLD cycle -> kbd_out=0 next cycle, GAP begins. rst mid-HOLD with 2 queued -> all outputs 0, queue empty, no later display.

Source files
------------

// File: rtl/keypad_kbd_bridge.sv
// Bridges keypad scanner key events into a Hack-style KBD register value.
// Events are queued as raw indices, mapped to ASCII on display, held, then released.
module keypad_kbd_bridge #(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 1000000,
  parameter int GAP_CYCLES  = 1000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    key_index,
  input  logic                          key_valid,
  input  logic                          kbd_clear,
  output logic [15:0]                   kbd_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          busy
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int MAX_C  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TMR_W  = (MAX_C > 1) ? $clog2(MAX_C) : 1;
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);

  // Handshake: key_valid is a single-cycle strobe with no ready; an event
  // is taken on the edge it is high, or dropped (sticky overflow) if full.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [15:0]        kbd_q, kbd_d;
  logic [3:0]         mem_q [FIFO_DEPTH];
  logic [3:0]         mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               pop;
  logic               push;

  function automatic logic [7:0] key_ascii(input logic [3:0] idx);
    logic [7:0] code;
    case (idx)
      4'd0:    code = 8'h31;
      4'd1:    code = 8'h32;
      4'd2:    code = 8'h33;
      4'd3:    code = 8'h41;
      4'd4:    code = 8'h34;
      4'd5:    code = 8'h35;
      4'd6:    code = 8'h36;
      4'd7:    code = 8'h42;
      4'd8:    code = 8'h37;
      4'd9:    code = 8'h38;
      4'd10:   code = 8'h39;
      4'd11:   code = 8'h43;
      4'd12:   code = 8'h2A;
      4'd13:   code = 8'h30;
      4'd14:   code = 8'h23;
      default: code = 8'h44;
    endcase
    return code;
  endfunction

  // Display FSM: the pop decision uses the registered count, so the FIFO is never bypassed.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    kbd_d   = kbd_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        kbd_d = 16'h0000;
        if (count_q != '0) begin
          pop     = 1'b1;
          kbd_d   = {8'h00, key_ascii(mem_q[rd_ptr_q])};
          timer_d = '0;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if ((timer_q == HOLD_LAST) || kbd_clear) begin
          kbd_d   = 16'h0000;
          timer_d = '0;
          state_d = ST_GAP;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_GAP: begin
        kbd_d = 16'h0000;
        if (timer_q == GAP_LAST) begin
          timer_d = '0;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: begin
        kbd_d   = 16'h0000;
        timer_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // A full FIFO still accepts when the head leaves on the same edge.
  always_comb begin
    push       = key_valid && ((count_q < DEPTH_C) || pop);
    overflow_d = overflow_q || (key_valid && !push);
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = key_index;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      kbd_q      <= 16'h0000;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 4'h0;
      end
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      kbd_q      <= kbd_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign kbd_out    = kbd_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_keypad_kbd_bridge.sv
// Directed and random checks of keypad_kbd_bridge against an event-level
// queue/countdown model of the display timing.
module tb_keypad_kbd_bridge;

  localparam int D = 4;
  localparam int H = 8;
  localparam int G = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic        kbd_clear;
  logic [3:0]  key_index;
  logic [15:0] kbd_out;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic        busy;

  keypad_kbd_bridge #(
    .FIFO_DEPTH  (D),
    .HOLD_CYCLES (H),
    .GAP_CYCLES  (G)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_index  (key_index),
    .key_valid  (key_valid),
    .kbd_clear  (kbd_clear),
    .kbd_out    (kbd_out),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    m_q[$];
  int    m_disp   = 0;
  int    m_hold   = 0;
  int    m_gap    = 0;
  bit    m_ovf    = 1'b0;
  string keymap   = "123A456B789C*0#D";
  int    got_q[$];
  logic [15:0] prev_kbd = 16'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: display holds H cycles from the pop, then G cycles of zero, then one idle cycle.
  task automatic model_edge(input bit r, input bit kv, input int ki, input bit clr);
    bit pop;
    bit acc;
    int idx;
    if (r) begin
      m_q.delete();
      m_disp = 0;
      m_hold = 0;
      m_gap  = 0;
      m_ovf  = 1'b0;
    end else begin
      pop = (m_hold == 0) && (m_gap == 0) && (m_q.size() > 0);
      acc = kv && ((m_q.size() < D) || pop);
      if (kv && !acc) m_ovf = 1'b1;
      if (m_hold > 0) begin
        if (clr || m_hold == 1) begin
          m_disp = 0;
          m_hold = 0;
          m_gap  = G;
        end else begin
          m_hold--;
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else if (pop) begin
        idx    = m_q.pop_front();
        m_disp = keymap[idx];
        m_hold = H;
      end
      if (acc) m_q.push_back(ki);
    end
  endtask

  task automatic cycle(input bit r, input bit kv, input int ki, input bit clr);
    rst       = r;
    key_valid = kv;
    key_index = 4'(ki);
    kbd_clear = clr;
    @(posedge clk);
    model_edge(r, kv, ki, clr);
    @(negedge clk);
    check("kbd_out", 32'(kbd_out), 32'(m_disp));
    check("fifo_count", 32'(fifo_count), 32'(m_q.size()));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("busy", 32'(busy), 32'((m_hold > 0) || (m_gap > 0)));
    if (kbd_out != 16'h0 && prev_kbd == 16'h0) got_q.push_back(int'(kbd_out));
    prev_kbd = kbd_out;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    logic [7:0] map_exp [16];
    logic [7:0] ovf_exp [5];
    int nz;
    int bz;
    int guard;
    map_exp = '{8'h31, 8'h32, 8'h33, 8'h41, 8'h34, 8'h35, 8'h36, 8'h42,
                8'h37, 8'h38, 8'h39, 8'h43, 8'h2A, 8'h30, 8'h23, 8'h44};
    ovf_exp = '{8'h31, 8'h32, 8'h33, 8'h41, 8'h34};

    // Reset held 3 cycles with key_valid asserted.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 5, 1'b0);
    cycle(1'b0, 1'b0, 0, 1'b0);
    check("rst_kbd_out", 32'(kbd_out), 32'h0);
    check("rst_fifo_count", 32'(fifo_count), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);

    // Single key: two-cycle latency, exact hold and gap lengths.
    cycle(1'b0, 1'b1, 5, 1'b0);
    check("lat_e0", 32'(kbd_out), 32'h0);
    nz = 0;
    bz = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0, 0, 1'b0);
      if (i == 0) check("lat_e1", 32'(kbd_out), 32'h35);
      if (kbd_out == 16'h0035) nz++;
      if (busy) bz++;
    end
    check("single_hold_len", 32'(nz), 32'(H));
    check("single_busy_len", 32'(bz), 32'(H + G));

    // Full ASCII map.
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b1, i, 1'b0);
      cycle(1'b0, 1'b0, 0, 1'b0);
      check("map_code", 32'(kbd_out), 32'(map_exp[i]));
      idle(12);
    end

    // Overflow: six back-to-back events, the last one is dropped.
    cycle(1'b1, 1'b0, 0, 1'b0);
    got_q.delete();
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, i, 1'b0);
    idle(80);
    check("ovf_sticky", 32'(overflow), 32'h1);
    check("ovf_disp_count", 32'(got_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < got_q.size(); i++)
      check("ovf_disp_code", 32'(got_q[i]), 32'(ovf_exp[i]));

    // Full FIFO accepts a push on the same edge as the idle pop.
    cycle(1'b1, 1'b0, 0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, i, 1'b0);
    check("full_count", 32'(fifo_count), 32'd4);
    guard = 0;
    while (!(m_hold == 0 && m_gap == 0) && guard < 100) begin
      cycle(1'b0, 1'b0, 0, 1'b0);
      guard++;
    end
    check("full_wait_bound", 32'(guard < 100), 32'h1);
    cycle(1'b0, 1'b1, 9, 1'b0);
    check("same_edge_count", 32'(fifo_count), 32'd4);
    check("same_edge_ovf", 32'(overflow), 32'h0);
    check("same_edge_kbd", 32'(kbd_out), 32'h32);
    idle(70);

    // Early clear in the third hold cycle.
    cycle(1'b1, 1'b0, 0, 1'b0);
    cycle(1'b0, 1'b1, 7, 1'b0);
    cycle(1'b0, 1'b0, 0, 1'b0);
    check("clr_hold", 32'(kbd_out), 32'h42);
    idle(2);
    cycle(1'b0, 1'b0, 0, 1'b1);
    check("clr_kbd", 32'(kbd_out), 32'h0);
    check("clr_busy", 32'(busy), 32'h1);
    bz = 1;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b0, 0, 1'b1);
      if (busy) bz++;
    end
    check("clr_gap_len", 32'(bz), 32'(G));

    // Reset during hold drops the display and the queued events.
    for (int i = 1; i < 4; i++) cycle(1'b0, 1'b1, i, 1'b0);
    idle(2);
    check("mid_queued", 32'(fifo_count), 32'd2);
    cycle(1'b1, 1'b0, 0, 1'b0);
    check("mid_rst_kbd", 32'(kbd_out), 32'h0);
    check("mid_rst_count", 32'(fifo_count), 32'h0);
    nz = 0;
    for (int i = 0; i < 30; i++) begin
      cycle(1'b0, 1'b0, 0, 1'b0);
      if (kbd_out != 16'h0) nz++;
    end
    check("mid_no_display", 32'(nz), 32'h0);

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) == 0),
            int'($urandom_range(0, 15)), ($urandom_range(0, 15) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
